// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction fetch bus bundle (ROM read port and decode
//               valid/ready output).
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              inst_valid;
    logic              id_ready;
    logic [DATA_W-1:0] inst_o;
    logic [31:0]       pc_o;

    // Fetch stage side
    modport master (
        output rom_ce, rom_addr, inst_valid, inst_o, pc_o,
        input  rom_data, id_ready
    );

    // ROM and decode side
    modport slave (
        input  rom_ce, rom_addr, inst_valid, inst_o, pc_o,
        output rom_data, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage: owns the PC, reads the instruction
//               ROM and holds {pc, inst} in a one-entry valid/ready register.
//               Optional: IF_ALIGN_CHECK_EN adds the sticky misalign output.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_target,
    inst_fetch_if.master     bus,
`ifdef IF_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic [31:0]      fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_pc_o;
    logic [31:0]       r_fetch_cnt;
    logic [DATA_W-1:0] r_inst;
    logic              r_valid;
    logic              w_take;
    logic              w_halt;
    logic [31:0]       w_br_pc;

    // Branch targets are word aligned by dropping the byte offset.
    assign w_br_pc = {br_target[31:2], 2'b00};

`ifdef IF_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_halt   = r_misalign;
    assign misalign = r_misalign;
`else
    logic w_unused_bits;
    assign w_halt        = 1'b0;
    assign w_unused_bits = ^br_target[1:0];
`endif

    // A fetch happens only when the output slot is free or being drained now.
    assign w_take = (r_state == S_RUN) && en && !br_taken
                    && (!r_valid || bus.id_ready) && !w_halt;

    assign bus.rom_ce     = w_take;
    assign bus.rom_addr   = (r_state == S_BOOT) ? '0 : r_pc[ADDR_W+1:2];
    assign bus.inst_valid = r_valid;
    assign bus.inst_o     = r_inst;
    assign bus.pc_o       = r_pc_o;
    assign fetch_cnt      = r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_valid     <= 1'b0;
            r_inst      <= '0;
            r_pc_o      <= '0;
            r_fetch_cnt <= '0;
`ifdef IF_ALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_BOOT:  r_state <= en ? S_RUN : S_PAUSE;
                S_RUN:   if (!en) r_state <= S_PAUSE;
                S_PAUSE: if (en)  r_state <= S_RUN;
                default: r_state <= S_BOOT;
            endcase

            // Redirect wins over capture and drain; it also flushes the slot.
            if (br_taken) begin
                r_pc    <= w_br_pc;
                r_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
                if (br_target[1:0] != 2'b00) r_misalign <= 1'b1;
`endif
            end else if (w_take) begin
                r_inst      <= bus.rom_data;
                r_pc_o      <= r_pc;
                r_valid     <= 1'b1;
                r_pc        <= r_pc + 32'd4;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else if (r_valid && bus.id_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch: directed scenarios then
//               random traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        br  = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        rdy = 1'b1;
    logic [31:0] fetch_cnt;
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_boot, m_run, m_valid, m_mis;
    logic [31:0] m_pc, m_inst, m_pco, m_cnt;

    inst_fetch_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    inst_fetch #(.ADDR_W(10), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .br_taken  (br),
        .br_target (tgt),
        .bus       (bus),
`ifdef IF_ALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {22'd0, a} + 32'h100;
    endfunction

    assign bus.rom_data = bus.rom_ce ? rom_word(bus.rom_addr) : 32'hz;
    assign bus.id_ready = rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_run = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
        m_pc = 32'h0; m_inst = 32'h0; m_pco = 32'h0; m_cnt = 32'h0;
    endtask

    function automatic logic exp_take();
        return m_run && en && !br && (!m_valid || rdy) && !m_mis;
    endfunction

    task automatic check_all();
        logic [31:0] addr;
        addr = m_boot ? 32'h0 : {22'd0, m_pc[11:2]};
        chk("rom_ce",     {31'd0, bus.rom_ce},     {31'd0, exp_take()});
        chk("rom_addr",   {22'd0, bus.rom_addr},   addr);
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
        chk("inst_o",     bus.inst_o,              m_inst);
        chk("pc_o",       bus.pc_o,                m_pco);
        chk("fetch_cnt",  fetch_cnt,               m_cnt);
`ifdef IF_ALIGN_CHECK_EN
        chk("misalign",   {31'd0, misalign},       {31'd0, m_mis});
`endif
    endtask

    // One clock: check settled outputs, advance the model with the present inputs.
    task automatic tick();
        logic t;
        @(negedge clk);
        check_all();
        t = exp_take();
        if (rst) begin
            model_reset();
        end else begin
            m_boot = 1'b0;
            m_run  = en;
            if (br) begin
                m_pc    = {tgt[31:2], 2'b00};
                m_valid = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
`endif
            end else if (t) begin
                m_inst  = rom_word(m_pc[11:2]);
                m_pco   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_cnt   = m_cnt + 32'd1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        tick();
        chk("reset_rom_ce", {31'd0, bus.rom_ce}, 32'd0);
        chk("reset_cnt", fetch_cnt, 32'd0);

        // sequential fetch from reset
        rst = 1'b0;
        tick();                      // BOOT cycle
        tick();
        chk("seq0_inst", bus.inst_o, 32'h100);
        chk("seq0_pc",   bus.pc_o,   32'h0);
        tick();
        chk("seq1_inst", bus.inst_o, 32'h101);
        chk("seq1_pc",   bus.pc_o,   32'h4);

        // stall on 0x101, then release
        rdy = 1'b0;
        repeat (3) tick();
        chk("stall_inst", bus.inst_o, 32'h101);
        chk("stall_ce",   {31'd0, bus.rom_ce}, 32'd0);
        chk("stall_addr", {22'd0, bus.rom_addr}, 32'd2);
        rdy = 1'b1;
        tick();
        chk("release_inst", bus.inst_o, 32'h102);
        chk("release_pc",   bus.pc_o,   32'h8);
        chk("release_cnt",  fetch_cnt,  32'd3);

        // redirect while stalled
        tick();
        rdy = 1'b0;
        tick();
        br = 1'b1; tgt = 32'h40;
        tick();
        br = 1'b0; rdy = 1'b1;
        chk("br_flush", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        chk("br_inst", bus.inst_o, 32'h110);
        chk("br_pc",   bus.pc_o,   32'h40);

        // pause and resume
        en = 1'b0;
        repeat (2) tick();
        chk("pause_drain", {31'd0, bus.inst_valid}, 32'd0);
        en = 1'b1;
        repeat (2) tick();
        chk("resume_pc",   bus.pc_o,   32'h44);
        chk("resume_inst", bus.inst_o, 32'h111);

        // reset while stalled with a valid output
        rdy = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b1;
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_cnt",   fetch_cnt, 32'd0);
        tick();
        repeat (2) tick();

        // misaligned redirect
        br = 1'b1; tgt = 32'h42;
        tick();
        br = 1'b0;
        tick();
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_ce",   {31'd0, bus.rom_ce}, 32'd0);
`else
        chk("mis_pc",   bus.pc_o,   32'h40);
        chk("mis_inst", bus.inst_o, 32'h110);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // wrap of pc past 2^32 and aliasing above ROM depth
        tick();
        br = 1'b1; tgt = 32'hFFFF_FFF8;
        tick();
        br = 1'b0;
        repeat (4) tick();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8;
                1:       tgt = $urandom & 32'hFFFF_FFFC;
                2:       tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                default: tgt = $urandom;
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
